// File: rtl/bcd_time_setter_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_time_setter_if
// Purpose  : Time bus between the BCD time setter and the 12-hour clock core.
//            It carries the clock's current time into the setter, and the
//            edited time, commit strobe and edit status back out.
// Ports    : none (signal bundle only)
//            master : setter side (reads *_in, drives *_out/load/setting/field)
//            slave  : clock side (drives *_in, reads *_out/load/setting/field)
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_time_setter_if;
  logic [7:0] hh_in;    // current hours, BCD 01..12
  logic [7:0] mm_in;    // current minutes, BCD 00..59
  logic       pm_in;    // current PM flag
  logic [7:0] hh_out;   // edited hours, BCD
  logic [7:0] mm_out;   // edited minutes, BCD
  logic       pm_out;   // edited PM flag
  logic       load;     // one-cycle commit strobe
  logic       setting;  // edit in progress, freezes the clock
  logic [1:0] field;    // 00 idle, 01 hours, 10 minutes, 11 commit

  modport master (
    input  hh_in, mm_in, pm_in,
    output hh_out, mm_out, pm_out, load, setting, field
  );

  modport slave (
    output hh_in, mm_in, pm_in,
    input  hh_out, mm_out, pm_out, load, setting, field
  );
endinterface
`default_nettype wire

// File: rtl/bcd_time_setter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_time_setter
// Purpose  : Write-side front end of the 12-hour BCD clock. Debounces the
//            mode and increment buttons, runs the hours/minutes edit state
//            machine and commits the edited time with a one-cycle load.
// Ports    : clk       - single clock, rising edge
//            reset     - asynchronous active-high reset
//            btn_mode  - raw mode button, high = pressed
//            btn_inc   - raw increment button, high = pressed
//            bus       - time bus (master side): *_in current time,
//                        *_out edited time, load, setting, field
// Revision : 1.0 - initial release
// ============================================================================
module bcd_time_setter #(
  parameter int unsigned DB_CYCLES = 3,
  parameter int unsigned TIMEOUT   = 64
) (
  input  wire                       clk,
  input  wire                       reset,
  input  wire                       btn_mode,
  input  wire                       btn_inc,
  bcd_time_setter_if.master         bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_db_w = $clog2(DB_CYCLES + 1);
  localparam int c_to_w = $clog2(TIMEOUT);

  localparam logic [c_db_w-1:0] c_db_one  = c_db_w'(1);
  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DB_CYCLES - 1);
  localparam logic [c_to_w-1:0] c_to_one  = c_to_w'(1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 1);

  // State codes equal the field codes so the state register drives field.
  localparam logic [1:0] c_st_idle   = 2'b00;
  localparam logic [1:0] c_st_hr     = 2'b01;
  localparam logic [1:0] c_st_min    = 2'b10;
  localparam logic [1:0] c_st_commit = 2'b11;

  localparam int c_btn_mode = 0;
  localparam int c_btn_inc  = 1;

  // --------------------------------------------------------------------------
  // Button conditioning: synchronizer, stability counter, rising-edge pulse
  // --------------------------------------------------------------------------
  wire  [1:0] w_btn_raw;
  logic [1:0] w_event;

  assign w_btn_raw = {btn_inc, btn_mode};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic              r_sync1;
      logic              r_sync2;
      logic              r_level;
      logic              r_level_q;
      logic              r_event;
      logic [c_db_w-1:0] r_db_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_sync1   <= 1'b0;
          r_sync2   <= 1'b0;
          r_level   <= 1'b0;
          r_level_q <= 1'b0;
          r_event   <= 1'b0;
          r_db_cnt  <= '0;
        end else begin
          r_sync1   <= w_btn_raw[gi];
          r_sync2   <= r_sync1;
          r_level_q <= r_level;
          // Pulse only on the debounced rising edge; releases are silent.
          r_event   <= r_level & ~r_level_q;

          if (r_sync2 == r_level) begin
            r_db_cnt <= '0;
          end else if (r_db_cnt == c_db_last) begin
            // The count would reach DB_CYCLES on this sample: accept level.
            r_level  <= r_sync2;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + c_db_one;
          end
        end
      end

      assign w_event[gi] = r_event;
    end
  endgenerate

  wire w_ev_mode = w_event[c_btn_mode];
  wire w_ev_inc  = w_event[c_btn_inc];

  // --------------------------------------------------------------------------
  // BCD helpers
  // --------------------------------------------------------------------------
  function automatic logic [7:0] f_sanitize_hh(input logic [7:0] hh);
    logic ok;
    ok = ((hh[7:4] == 4'd0) && (hh[3:0] >= 4'd1) && (hh[3:0] <= 4'd9)) ||
         ((hh[7:4] == 4'd1) && (hh[3:0] <= 4'd2));
    return ok ? hh : 8'h12;
  endfunction

  function automatic logic [7:0] f_sanitize_mm(input logic [7:0] mm);
    logic ok;
    ok = (mm[7:4] <= 4'd5) && (mm[3:0] <= 4'd9);
    return ok ? mm : 8'h00;
  endfunction

  // Hours are always valid here, so only 09 and 12 need special handling.
  function automatic logic [7:0] f_inc_hh(input logic [7:0] hh);
    logic [7:0] nxt;
    case (hh)
      8'h12:   nxt = 8'h01;
      8'h09:   nxt = 8'h10;
      default: nxt = hh + 8'd1;
    endcase
    return nxt;
  endfunction

  function automatic logic [7:0] f_inc_mm(input logic [7:0] mm);
    logic [7:0] nxt;
    if (mm[3:0] == 4'd9) begin
      nxt = (mm[7:4] == 4'd5) ? 8'h00 : {mm[7:4] + 4'd1, 4'd0};
    end else begin
      nxt = {mm[7:4], mm[3:0] + 4'd1};
    end
    return nxt;
  endfunction

  // --------------------------------------------------------------------------
  // Edit state machine
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [7:0]        r_hh;
  logic [7:0]        r_mm;
  logic              r_pm;
  logic              r_load;
  logic              r_setting;
  logic [c_to_w-1:0] r_tmo;

  logic [1:0]        w_state_nxt;
  logic [7:0]        w_hh_nxt;
  logic [7:0]        w_mm_nxt;
  logic              w_pm_nxt;
  logic [c_to_w-1:0] w_tmo_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_hh_nxt    = r_hh;
    w_mm_nxt    = r_mm;
    w_pm_nxt    = r_pm;
    w_tmo_nxt   = r_tmo;

    case (r_state)
      c_st_idle: begin
        w_tmo_nxt = '0;
        if (w_ev_mode) begin
          w_hh_nxt    = f_sanitize_hh(bus.hh_in);
          w_mm_nxt    = f_sanitize_mm(bus.mm_in);
          w_pm_nxt    = bus.pm_in;
          w_state_nxt = c_st_hr;
        end
      end

      c_st_hr: begin
        // Mode wins over a simultaneous inc.
        if (w_ev_mode) begin
          w_state_nxt = c_st_min;
          w_tmo_nxt   = '0;
        end else if (w_ev_inc) begin
          w_hh_nxt  = f_inc_hh(r_hh);
          // Only the 11 -> 12 step crosses noon/midnight.
          w_pm_nxt  = (r_hh == 8'h11) ? ~r_pm : r_pm;
          w_tmo_nxt = '0;
        end else if (r_tmo == c_to_last) begin
          w_state_nxt = c_st_idle;
          w_tmo_nxt   = '0;
        end else begin
          w_tmo_nxt = r_tmo + c_to_one;
        end
      end

      c_st_min: begin
        if (w_ev_mode) begin
          w_state_nxt = c_st_commit;
          w_tmo_nxt   = '0;
        end else if (w_ev_inc) begin
          w_mm_nxt  = f_inc_mm(r_mm);
          w_tmo_nxt = '0;
        end else if (r_tmo == c_to_last) begin
          w_state_nxt = c_st_idle;
          w_tmo_nxt   = '0;
        end else begin
          w_tmo_nxt = r_tmo + c_to_one;
        end
      end

      c_st_commit: begin
        // Single-cycle state; any event seen here is dropped.
        w_state_nxt = c_st_idle;
        w_tmo_nxt   = '0;
      end

      default: begin
        w_state_nxt = c_st_idle;
        w_tmo_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= c_st_idle;
      r_hh      <= 8'h12;
      r_mm      <= 8'h00;
      r_pm      <= 1'b0;
      r_load    <= 1'b0;
      r_setting <= 1'b0;
      r_tmo     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_hh      <= w_hh_nxt;
      r_mm      <= w_mm_nxt;
      r_pm      <= w_pm_nxt;
      r_tmo     <= w_tmo_nxt;
      // Status outputs are decoded from the next state so they line up
      // with the state register rather than lagging it by a cycle.
      r_load    <= (w_state_nxt == c_st_commit);
      r_setting <= (w_state_nxt != c_st_idle);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all registered)
  // --------------------------------------------------------------------------
  assign bus.hh_out  = r_hh;
  assign bus.mm_out  = r_mm;
  assign bus.pm_out  = r_pm;
  assign bus.load    = r_load;
  assign bus.setting = r_setting;
  assign bus.field   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bcd_time_setter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_time_setter
// Purpose  : Scoreboard bench for bcd_time_setter. Stimulus pushes the
//            expected observable state (and optionally the exact cycle it
//            must appear) whenever it issues a press; a monitor pops and
//            compares every time the DUT's observable outputs change.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_time_setter;

  localparam int DB = 3;
  localparam int TO = 64;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic btn_mode = 1'b0;
  logic btn_inc  = 1'b0;
  int   cyc      = 0;

  bcd_time_setter_if bus();

  bcd_time_setter #(
    .DB_CYCLES (DB),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic       pm;
    logic [1:0] field;
    logic       setting;
    logic       load;
  } obs_t;

  obs_t  exp_q[$];
  int    cyc_q[$];
  string name_q[$];

  int   n_checks = 0;
  int   n_fails  = 0;
  bit   mon_en   = 1'b0;
  obs_t prev;
  obs_t cur;

  initial prev = 'x;

  function automatic obs_t mk(input logic [7:0] h, input logic [7:0] m,
                              input logic p, input logic [1:0] f,
                              input logic s, input logic l);
    obs_t o;
    o = {h, m, p, f, s, l};
    return o;
  endfunction

  task automatic expect_at(input obs_t e, input int c, input string n);
    exp_q.push_back(e);
    cyc_q.push_back(c);
    name_q.push_back(n);
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {bus.hh_out, bus.mm_out, bus.pm_out, bus.field, bus.setting, bus.load};
      if (cur !== prev) begin
        prev = cur;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_change at cycle %0d: got hh=%h mm=%h pm=%b field=%b setting=%b load=%b, required no change",
                   cyc, cur.hh, cur.mm, cur.pm, cur.field, cur.setting, cur.load);
        end else begin
          obs_t  e;
          int    c;
          string n;
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          n = name_q.pop_front();
          n_checks++;
          if (cur !== e) begin
            n_fails++;
            $display("FAIL %s: got hh=%h mm=%h pm=%b field=%b setting=%b load=%b, required hh=%h mm=%h pm=%b field=%b setting=%b load=%b",
                     n, cur.hh, cur.mm, cur.pm, cur.field, cur.setting, cur.load,
                     e.hh, e.mm, e.pm, e.field, e.setting, e.load);
          end
          if (c >= 0) begin
            n_checks++;
            if (cyc != c) begin
              n_fails++;
              $display("FAIL %s_timing: got cycle %0d, required cycle %0d", n, cyc, c);
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic press_start(input logic m, input logic i, output int k);
    @(negedge clk);
    k        = cyc;
    btn_mode = m;
    btn_inc  = i;
  endtask

  task automatic press_end();
    repeat (8) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // A press whose result appears DB+4 cycles after the first-sample cycle.
  task automatic press(input logic m, input logic i, input obs_t e,
                       input bit timed, input string n);
    int k;
    press_start(m, i, k);
    expect_at(e, timed ? k + DB + 4 : -1, n);
    press_end();
  endtask

  initial begin
    int k;

    // Reset values
    repeat (3) @(negedge clk);
    expect_at(mk(8'h12, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0), -1, "reset_values");
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Capture 07:45 PM with exact latency
    bus.hh_in = 8'h07; bus.mm_in = 8'h45; bus.pm_in = 1'b1;
    press(1, 0, mk(8'h07, 8'h45, 1'b1, 2'b01, 1'b1, 1'b0), 1, "capture_0745pm");
    press(1, 0, mk(8'h07, 8'h45, 1'b1, 2'b10, 1'b1, 1'b0), 1, "to_set_min");
    press_start(1, 0, k);
    expect_at(mk(8'h07, 8'h45, 1'b1, 2'b11, 1'b1, 1'b1), k + DB + 4, "commit_0745");
    expect_at(mk(8'h07, 8'h45, 1'b1, 2'b00, 1'b0, 1'b0), k + DB + 5, "idle_after_commit_0745");
    press_end();

    // Inc in IDLE is ignored; the live inputs are not tracked either
    bus.hh_in = 8'h03;
    press(0, 1, mk(8'h07, 8'h45, 1'b1, 2'b00, 1'b0, 1'b0), 0, "idle_inc_ignored_unused");
    // The entry above is consumed by no change; drop it so it cannot linger.
    void'(exp_q.pop_back()); void'(cyc_q.pop_back()); void'(name_q.pop_back());

    // Hour wrap, PM toggle, minute wrap, commit
    bus.hh_in = 8'h10; bus.mm_in = 8'h58; bus.pm_in = 1'b0;
    press(1, 0, mk(8'h10, 8'h58, 1'b0, 2'b01, 1'b1, 1'b0), 1, "capture_1058am");
    press(0, 1, mk(8'h11, 8'h58, 1'b0, 2'b01, 1'b1, 1'b0), 1, "hr_10_to_11");
    press(0, 1, mk(8'h12, 8'h58, 1'b1, 2'b01, 1'b1, 1'b0), 1, "hr_11_to_12_pm");
    press(0, 1, mk(8'h01, 8'h58, 1'b1, 2'b01, 1'b1, 1'b0), 1, "hr_12_to_01_keep_pm");
    press(1, 0, mk(8'h01, 8'h58, 1'b1, 2'b10, 1'b1, 1'b0), 1, "to_set_min_2");
    press(0, 1, mk(8'h01, 8'h59, 1'b1, 2'b10, 1'b1, 1'b0), 1, "min_58_to_59");
    press(0, 1, mk(8'h01, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0), 1, "min_59_to_00");
    press_start(1, 0, k);
    expect_at(mk(8'h01, 8'h00, 1'b1, 2'b11, 1'b1, 1'b1), k + DB + 4, "commit_0100");
    expect_at(mk(8'h01, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0), k + DB + 5, "idle_after_commit_0100");
    press_end();

    // Debounce: glitch rejected, bouncing burst gives exactly one step
    bus.hh_in = 8'h09; bus.mm_in = 8'h15; bus.pm_in = 1'b0;
    press(1, 0, mk(8'h09, 8'h15, 1'b0, 2'b01, 1'b1, 1'b0), 1, "capture_0915");
    @(negedge clk);
    btn_inc = 1'b1;
    repeat (2) @(negedge clk);
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    expect_at(mk(8'h10, 8'h15, 1'b0, 2'b01, 1'b1, 1'b0), -1, "bounce_single_inc_09_to_10");
    for (int j = 0; j < 8; j++) begin
      btn_inc = (j % 2 == 0);
      @(negedge clk);
    end
    btn_inc = 1'b1;
    repeat (10) @(negedge clk);
    btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    press(1, 0, mk(8'h10, 8'h15, 1'b0, 2'b10, 1'b1, 1'b0), 1, "to_set_min_3");
    press_start(1, 0, k);
    expect_at(mk(8'h10, 8'h15, 1'b0, 2'b11, 1'b1, 1'b1), k + DB + 4, "commit_1015");
    expect_at(mk(8'h10, 8'h15, 1'b0, 2'b00, 1'b0, 1'b0), k + DB + 5, "idle_after_commit_1015");
    press_end();

    // Invalid capture, simultaneous mode+inc, then timeout in SET_MIN
    bus.hh_in = 8'h13; bus.mm_in = 8'h6A; bus.pm_in = 1'b1;
    press(1, 0, mk(8'h12, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0), 1, "sanitize_13_6a");
    press_start(1, 1, k);
    expect_at(mk(8'h12, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0), k + DB + 4, "simul_mode_wins");
    expect_at(mk(8'h12, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0), k + DB + 4 + TO, "timeout_no_load");
    press_end();
    repeat (TO + 10) @(negedge clk);

    // Re-enter edit, then reset mid-edit
    bus.hh_in = 8'h1A; bus.mm_in = 8'h37; bus.pm_in = 1'b0;
    press(1, 0, mk(8'h12, 8'h37, 1'b0, 2'b01, 1'b1, 1'b0), 1, "sanitize_1a_37");
    @(posedge clk);
    #2;
    expect_at(mk(8'h12, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0), cyc, "reset_mid_edit");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (TO + 10) @(negedge clk);

    // Anything still queued never appeared
    while (exp_q.size() > 0) begin
      string n;
      n = name_q.pop_front();
      void'(exp_q.pop_front());
      void'(cyc_q.pop_front());
      n_checks++;
      n_fails++;
      $display("FAIL %s: got no output change, required one", n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_time_setter.md
# bcd_time_setter

Write-side front end for the 12-hour BCD clock. Two raw pushbuttons are debounced and edge-detected. A mode/increment state machine lets the user edit hours, minutes and AM/PM. The edited time is committed with a single-cycle load pulse to the clock's preset inputs. It also drives `setting` to freeze the clock and `field` so the display path can blink the field being edited.

## Interface
- `DB_CYCLES`, default 3: consecutive synchronized samples a button must hold a new level before its debounced level changes (≥1).
- `TIMEOUT`, default 64: cycles without an accepted press in an edit state before edit is abandoned (≥2).
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- `btn_mode`  in  1  raw, asynchronous mode button; high = pressed.
- `btn_inc`  in  1  raw, asynchronous increment button; high = pressed.
- `hh_in`  in  8  current clock hours, BCD, valid range 01..12.
- `mm_in`  in  8  current clock minutes, BCD, valid range 00..59.
- `pm_in`  in  1  current clock PM flag.
- `hh_out`  out  8  edited hours, BCD.
- `mm_out`  out  8  edited minutes, BCD.
- `pm_out`  out  1  edited PM flag.
- `load`  out  1  one-cycle commit strobe; `hh_out`, `mm_out` and `pm_out` are valid in the same cycle.
- `setting`  out  1  high in SET_HR, SET_MIN and COMMIT; gates the clock enable upstream.
- `field`  out  2  00 idle, 01 hours, 10 minutes, 11 commit.

## Operation
- **Input conditioning**, per button:
  - 2-flop synchronizer.
  - Stability counter: counts while the synchronized value differs from the debounced level; clears when they match.
  - The debounced level flips when the counter would reach `DB_CYCLES`.
  - Press event is a registered, one-cycle pulse on the debounced rising edge. Releases generate nothing.
- **States**: IDLE, SET_HR, SET_MIN, COMMIT. Encoding is free; `field` carries the defined codes.
- **IDLE**:
  - Outputs hold their last values; they do not track the `*_in` inputs.
  - Mode event: capture `hh_in`, `mm_in`, `pm_in` into the outputs and go to SET_HR.
  - Inc event: ignored.
- **Capture sanitizing**:
  - Hours outside BCD 01..12 (including any nibble > 9) load as 8'h12.
  - Minutes outside 00..59 load as 8'h00.
- **SET_HR**:
  - Inc event steps hours 01→02…→09→10→11→12→01.
  - The 11→12 step toggles `pm_out`; the 12→01 step does not.
  - Mode event: go to SET_MIN.
- **SET_MIN**:
  - Inc event steps minutes 00→01…09→10…59→00.
  - No carry into hours.
  - Mode event: go to COMMIT.
- **COMMIT**: lasts exactly one cycle with `load`=1, then IDLE.
- **Simultaneous events**: mode and inc events in the same cycle act as mode only; the inc is dropped.
- **Timeout**:
  - The counter clears on entry to SET_HR and on every accepted event.
  - In SET_HR or SET_MIN, after `TIMEOUT` consecutive cycles without an event, go to IDLE with no `load`.
  - Edited values remain on the outputs but are not committed.
- **Events during COMMIT**: any press event arriving in COMMIT is discarded.
- **Reset mid-edit**: immediate IDLE, no `load`, all outputs return to reset values.

## Timing
- **Reset values**:
  - `hh_out`=8'h12, `mm_out`=8'h00, `pm_out`=0.
  - `load`=0, `setting`=0, `field`=2'b00.
  - Synchronizers, debounced levels, event pulses and all counters are 0.
- **Press latency**:
  - A raw press is first sampled at edge E.
  - The event pulse is high in the cycle after edge E+`DB_CYCLES`+2.
  - The FSM or output update is visible after edge E+`DB_CYCLES`+3. With the default, that is 6 edges.
- **Glitch rejection**: a raw pulse shorter than `DB_CYCLES` synchronized cycles never produces an event.
- **Outputs**: all outputs are registered; there are no combinational paths from inputs.
- **`load` qualification**:
  - `load` is high for exactly one cycle per completed edit, in the COMMIT cycle.
  - `setting` is also high in that cycle and falls on the next edge.
- **Throughput**: at most one accepted event per button per `DB_CYCLES`+1 cycles.

## Test plan
- **Reset and capture**: after reset, check reset values. Apply `hh_in`=8'h07, `mm_in`=8'h45, `pm_in`=1, then press mode. Exactly `DB_CYCLES`+3 edges after first sample: `field`=01, `setting`=1, `hh_out`=07, `mm_out`=45, `pm_out`=1.
- **Hour wrap and PM toggle**: capture 10 AM, then press inc 3 times. Hours go 11, 12 (`pm_out`→1), 01 (`pm_out` stays 1).
- **Minute wrap and commit**: in SET_MIN starting from 58, press inc twice. Minutes go 59 then 00 and hours are unchanged. Press mode: `load`=1 for one cycle with `field`=11, then IDLE with `setting`=0.
- **Debounce**: a raw `btn_inc` pulse of 2 cycles with `DB_CYCLES`=3 causes no change. A 1-cycle-period bouncing burst followed by a stable high produces exactly one increment.
- **Simultaneous presses and invalid capture**: with `hh_in`=8'h13 and `mm_in`=8'h6A, press mode. Captured values are 12 and 00. Next, press mode and inc together: only the mode action occurs (SET_MIN) and minutes stay 00.
- **Timeout and reset abort**: idle in SET_MIN for `TIMEOUT` cycles. Expect IDLE, no `load`, `setting`=0. Re-enter edit, then assert `reset` mid-edit: outputs return to 12/00/0 immediately and no `load` occurs.
